// File: rtl/join_pkg.sv
// join_pkg: shared widths, input packet layout, port constants and FSM
// state encodings for the join (operand-matching) stage.
package join_pkg;

   localparam int TAG_W_DEF  = 4;
   localparam int DATA_W_DEF = 16;

   // Operand side carried in the PORT field of an input packet.
   localparam bit PORT_L = 1'b0;
   localparam bit PORT_R = 1'b1;

   // Input packet layout, MSB to LSB: {MONO, PORT, TAG, DATA}.
   localparam int DATA_OFS = 0;

   function automatic int tag_ofs(input int data_w);
      return data_w;
   endfunction

   function automatic int port_ofs(input int tag_w, input int data_w);
      return tag_w + data_w;
   endfunction

   function automatic int mono_ofs(input int tag_w, input int data_w);
      return tag_w + data_w + 1;
   endfunction

   typedef enum logic [1:0] {
      IN_IDLE   = 2'd0,
      IN_LOOKUP = 2'd1,
      IN_REL    = 2'd2
   } in_state_t;

   typedef enum logic [1:0] {
      OUT_IDLE = 2'd0,
      OUT_REQ  = 2'd1,
      OUT_REL  = 2'd2
   } out_state_t;

endpackage

// File: rtl/join_match_mem.sv
// join_match_mem: tag-indexed matching memory of {valid, port, data}.
// One combinational read and one synchronous write per cycle; only the
// valid bits are reset, so every entry is empty after reset.
module join_match_mem #(
   parameter int TAG_W  = 4,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [TAG_W-1:0]  rd_addr,
   output logic              rd_valid,
   output logic              rd_port,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [TAG_W-1:0]  wr_addr,
   input  logic              wr_valid,
   input  logic              wr_port,
   input  logic [DATA_W-1:0] wr_data
);

   localparam int DEPTH = 1 << TAG_W;

   logic [DEPTH-1:0] valid_q;
   logic             port_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   // Valid bits: set on store, cleared on match, all cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_addr] <= wr_valid;
      end
   end

   // Payload storage, written only when an entry becomes valid.
   // NOTE: payload arrays are deliberately not reset; a cleared valid bit
   // already makes their contents unobservable, and resetting them would
   // turn a plain RAM into a large register file.
   always_ff @(posedge clk) begin
      if (wr_en && wr_valid) begin
         port_q[wr_addr] <= wr_port;
         data_q[wr_addr] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_addr];
   assign rd_port  = port_q[rd_addr];
   assign rd_data  = data_q[rd_addr];

endmodule

// File: rtl/join_match_stage.sv
// join_match_stage: clocked operand-matching stage. Parks the first operand
// of each tag, emits {TAG, DATA_L, DATA_R} when its partner arrives.
// Optional build macro JOIN_MONO_BYPASS_EN: a MONO=1 token fires directly
// with DATA_R=0 and leaves the matching memory untouched.
module join_match_stage
   import join_pkg::*;
#(
   parameter int TAG_W  = TAG_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                      CP,
   input  logic                      MR_N,
   input  logic                      Send_in,
   output logic                      Ack_out,
   input  logic [TAG_W+DATA_W+1:0]   PACKET_IN,
   output logic                      Send_out,
   input  logic                      Ack_in,
   output logic [TAG_W+2*DATA_W-1:0] PACKET_OUT,
   output logic                      ERR
);

   localparam int TAG_LSB  = tag_ofs(DATA_W);
   localparam int PORT_BIT = port_ofs(TAG_W, DATA_W);
   localparam int MONO_BIT = mono_ofs(TAG_W, DATA_W);

   in_state_t  in_state;
   out_state_t out_state;

   // Captured input token.
   logic [TAG_W-1:0]  in_tag;
   logic              in_port;
   logic [DATA_W-1:0] in_data;
   logic              in_mono;
   logic              mono_cap;

   // Matching memory interface.
   logic              rd_valid;
   logic              rd_port;
   logic [DATA_W-1:0] rd_data;
   logic              wr_en;
   logic              wr_valid;

   // Lookup-cycle decisions.
   logic                      do_store;
   logic                      do_match;
   logic                      do_collide;
   logic                      do_mono;
   logic                      fire;
   logic [TAG_W+2*DATA_W-1:0] fire_pkt;

`ifdef JOIN_MONO_BYPASS_EN
   assign mono_cap = PACKET_IN[MONO_BIT];
`else
   // MONO is ignored in this build; the bit is absorbed here so it is not
   // reported as a dangling input.
   logic unused_mono;
   assign unused_mono = PACKET_IN[MONO_BIT];
   assign mono_cap    = 1'b0;
`endif

   join_match_mem #(
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk      (CP),
      .rst_n    (MR_N),
      .rd_addr  (in_tag),
      .rd_valid (rd_valid),
      .rd_port  (rd_port),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_addr  (in_tag),
      .wr_valid (wr_valid),
      .wr_port  (in_port),
      .wr_data  (in_data)
   );

   // Classify the captured token against its memory entry and build the
   // outgoing packet with left/right placed by PORT.
   always_comb begin
      // NOTE: every signal gets a default first so no path infers a latch.
      do_store   = 1'b0;
      do_match   = 1'b0;
      do_collide = 1'b0;
      do_mono    = 1'b0;
      fire_pkt   = '0;
      if (in_state == IN_LOOKUP) begin
         if (in_mono)               do_mono    = 1'b1;
         else if (!rd_valid)        do_store   = 1'b1;
         else if (rd_port != in_port) do_match = 1'b1;
         else                       do_collide = 1'b1;
      end
      if (do_mono)
         fire_pkt = {in_tag, in_data, {DATA_W{1'b0}}};
      else if (in_port == PORT_L)
         fire_pkt = {in_tag, in_data, rd_data};
      else
         fire_pkt = {in_tag, rd_data, in_data};
   end

   assign fire     = do_match | do_mono;
   assign wr_en    = do_store | do_match;
   assign wr_valid = do_store;

   // Input FSM: capture when downstream is idle, one lookup cycle, then a
   // 4-phase release of the upstream handshake.
   always_ff @(posedge CP or negedge MR_N) begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      if (!MR_N) begin
         in_state <= IN_IDLE;
         Ack_out  <= 1'b0;
         ERR      <= 1'b0;
         in_tag   <= '0;
         in_port  <= 1'b0;
         in_data  <= '0;
         in_mono  <= 1'b0;
      end else begin
         case (in_state)
            IN_IDLE: begin
               if (Send_in && out_state == OUT_IDLE) begin
                  in_tag   <= PACKET_IN[TAG_LSB +: TAG_W];
                  in_port  <= PACKET_IN[PORT_BIT];
                  in_data  <= PACKET_IN[DATA_OFS +: DATA_W];
                  in_mono  <= mono_cap;
                  in_state <= IN_LOOKUP;
               end
            end
            IN_LOOKUP: begin
               Ack_out  <= 1'b1;
               if (do_collide) ERR <= 1'b1;
               in_state <= IN_REL;
            end
            IN_REL: begin
               if (!Send_in) begin
                  Ack_out  <= 1'b0;
                  in_state <= IN_IDLE;
               end
            end
            default: begin
               Ack_out  <= 1'b0;
               in_state <= IN_IDLE;
            end
         endcase
      end
   end

   // Output FSM: raise Send_out with the packet on fire, drop it on Ack_in,
   // return to idle once Ack_in is released. PACKET_OUT changes only on fire.
   always_ff @(posedge CP or negedge MR_N) begin
      if (!MR_N) begin
         out_state  <= OUT_IDLE;
         Send_out   <= 1'b0;
         PACKET_OUT <= '0;
      end else begin
         case (out_state)
            OUT_IDLE: begin
               if (fire) begin
                  PACKET_OUT <= fire_pkt;
                  Send_out   <= 1'b1;
                  out_state  <= OUT_REQ;
               end
            end
            OUT_REQ: begin
               if (Ack_in) begin
                  Send_out  <= 1'b0;
                  out_state <= OUT_REL;
               end
            end
            OUT_REL: begin
               if (!Ack_in) out_state <= OUT_IDLE;
            end
            default: begin
               Send_out  <= 1'b0;
               out_state <= OUT_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_join_match_stage.sv
// tb_join_match_stage: directed and randomized token streams against a
// tag-table reference model of the join stage.
`timescale 1ns/1ps
module tb_join_match_stage;
   import join_pkg::*;

   localparam int TW = TAG_W_DEF;
   localparam int DW = DATA_W_DEF;
`ifdef JOIN_MONO_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic              CP = 1'b0;
   logic              MR_N = 1'b0;
   logic              Send_in = 1'b0;
   logic              Ack_in = 1'b0;
   logic [TW+DW+1:0]  PACKET_IN = '0;
   logic              Ack_out;
   logic              Send_out;
   logic              ERR;
   logic [TW+2*DW-1:0] PACKET_OUT;

   always #5 CP = ~CP;

   join_match_stage #(.TAG_W(TW), .DATA_W(DW)) dut (
      .CP         (CP),
      .MR_N       (MR_N),
      .Send_in    (Send_in),
      .Ack_out    (Ack_out),
      .PACKET_IN  (PACKET_IN),
      .Send_out   (Send_out),
      .Ack_in     (Ack_in),
      .PACKET_OUT (PACKET_OUT),
      .ERR        (ERR)
   );

   int checks_total  = 0;
   int checks_passed = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks_total++;
      if (got === exp) checks_passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Reference model: a table of parked operands per tag plus the sticky error.
   bit                m_valid [1<<TW];
   bit                m_port  [1<<TW];
   logic [DW-1:0]     m_data  [1<<TW];
   bit                m_err;
   bit                pending;
   logic [TW+2*DW-1:0] pend_pkt;

   function automatic void model_reset();
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_err = 1'b0;
   endfunction

   function automatic void model_step(input bit mono, input bit port, input logic [TW-1:0] tag,
                                      input logic [DW-1:0] data, output bit fire,
                                      output logic [TW+2*DW-1:0] pkt);
      logic [DW-1:0] left, right;
      fire = 1'b0;
      pkt  = '0;
      if (BYPASS && mono) begin
         fire = 1'b1;
         pkt  = {tag, data, {DW{1'b0}}};
      end else if (!m_valid[tag]) begin
         m_valid[tag] = 1'b1;
         m_port[tag]  = port;
         m_data[tag]  = data;
      end else if (m_port[tag] != port) begin
         left  = port ? m_data[tag] : data;
         right = port ? data : m_data[tag];
         fire  = 1'b1;
         pkt   = {tag, left, right};
         m_valid[tag] = 1'b0;
      end else begin
         m_err = 1'b1;
      end
   endfunction

   // Downstream receiver: accept the pending packet after a random delay.
   task automatic complete_output();
      int n;
      check("out_req", Send_out, 1'b1);
      check("out_pkt", PACKET_OUT, pend_pkt);
      repeat ($urandom_range(0, 3)) @(negedge CP);
      check("out_hold", PACKET_OUT, pend_pkt);
      Ack_in = 1'b1;
      n = 0;
      while (Send_out && n < 20) begin @(negedge CP); n++; end
      check("out_drop", Send_out, 1'b0);
      check("out_stable", PACKET_OUT, pend_pkt);
      Ack_in = 1'b0;
      @(negedge CP);
      pending = 1'b0;
   endtask

   // Upstream sender: one full 4-phase token. With bp>0 and an output still
   // pending, the token is held against the busy output for bp cycles first.
   task automatic send_token(input bit mono, input bit port, input logic [TW-1:0] tag,
                             input logic [DW-1:0] data, input int bp,
                             output bit got_fire, output logic [TW+2*DW-1:0] got_pkt);
      bit exp_fire;
      logic [TW+2*DW-1:0] exp_pkt;
      int n;
      bit lat_check;
      if (pending && bp == 0) complete_output();
      lat_check = !pending;
      model_step(mono, port, tag, data, exp_fire, exp_pkt);
      @(negedge CP);
      PACKET_IN = {mono, port, tag, data};
      Send_in   = 1'b1;
      if (pending) begin
         for (int i = 0; i < bp; i++) begin
            @(negedge CP);
            check("bp_hold_ack", Ack_out, 1'b0);
         end
         complete_output();
      end
      n = 0;
      while (!Ack_out && n < 50) begin @(negedge CP); n++; end
      check("ack_rise", Ack_out, 1'b1);
      if (lat_check) check("ack_latency", n, 2);
      got_fire = Send_out;
      got_pkt  = PACKET_OUT;
      check("fire", Send_out, exp_fire);
      check("err", ERR, m_err);
      if (exp_fire) check("pkt", PACKET_OUT, exp_pkt);
      Send_in = 1'b0;
      n = 0;
      while (Ack_out && n < 50) begin @(negedge CP); n++; end
      check("ack_fall", Ack_out, 1'b0);
      if (exp_fire) begin
         pending  = 1'b1;
         pend_pkt = exp_pkt;
      end
   endtask

   initial begin
      bit f;
      logic [TW+2*DW-1:0] p;
      int n;
      model_reset();
      pending = 1'b0;

      // Reset state.
      repeat (3) @(negedge CP);
      check("rst0_ack", Ack_out, 1'b0);
      check("rst0_send", Send_out, 1'b0);
      check("rst0_err", ERR, 1'b0);
      check("rst0_pkt", PACKET_OUT, '0);
      MR_N = 1'b1;
      @(negedge CP);

      // Park tag 3, raise ERR, then reset in the middle of a firing handshake.
      send_token(0, PORT_L, 4'd3, 16'h1234, 0, f, p);
      send_token(0, PORT_L, 4'd12, 16'h0001, 0, f, p);
      send_token(0, PORT_L, 4'd12, 16'h0002, 0, f, p);
      send_token(0, PORT_L, 4'd1, 16'hAAAA, 0, f, p);
      @(negedge CP);
      PACKET_IN = {1'b0, PORT_R, 4'd1, 16'hBBBB};
      Send_in   = 1'b1;
      n = 0;
      while (!Ack_out && n < 50) begin @(negedge CP); n++; end
      check("pre_rst_send", Send_out, 1'b1);
      check("pre_rst_err", ERR, 1'b1);
      #2 MR_N = 1'b0;
      #1;
      check("rst_send", Send_out, 1'b0);
      check("rst_ack", Ack_out, 1'b0);
      check("rst_err", ERR, 1'b0);
      check("rst_pkt", PACKET_OUT, '0);
      Send_in = 1'b0;
      model_reset();
      pending = 1'b0;
      @(negedge CP);
      MR_N = 1'b1;
      @(negedge CP);

      // Tag 3 must be empty again: a left token parks instead of colliding.
      send_token(0, PORT_L, 4'd3, 16'h1234, 0, f, p);
      check("t3_first_nofire", f, 1'b0);
      check("t3_first_noerr", ERR, 1'b0);
      send_token(0, PORT_R, 4'd3, 16'h00FF, 0, f, p);
      check("t3_fire", f, 1'b1);
      check("t3_pkt", p, {4'd3, 16'h1234, 16'h00FF});
      send_token(0, PORT_R, 4'd3, 16'h0042, 0, f, p);
      check("t3_cleared", f, 1'b0);
      send_token(0, PORT_L, 4'd3, 16'h0043, 0, f, p);

      // Right-first ordering.
      send_token(0, PORT_R, 4'd5, 16'hAAAA, 0, f, p);
      send_token(0, PORT_L, 4'd5, 16'h5555, 0, f, p);
      check("t5_pkt", p, {4'd5, 16'h5555, 16'hAAAA});

      // Collision keeps the stored operand.
      send_token(0, PORT_L, 4'd7, 16'h0001, 0, f, p);
      send_token(0, PORT_L, 4'd7, 16'h0002, 0, f, p);
      check("t7_coll_nofire", f, 1'b0);
      check("t7_coll_err", ERR, 1'b1);
      send_token(0, PORT_R, 4'd7, 16'h0003, 0, f, p);
      check("t7_pkt", p, {4'd7, 16'h0001, 16'h0003});

      // Back-pressure: next token waits 10 cycles on an unacknowledged output.
      send_token(0, PORT_L, 4'd9, 16'h1111, 0, f, p);
      send_token(0, PORT_R, 4'd9, 16'h2222, 0, f, p);
      send_token(0, PORT_L, 4'd10, 16'h3333, 10, f, p);
      send_token(0, PORT_R, 4'd10, 16'h4444, 0, f, p);
      check("t10_pkt", p, {4'd10, 16'h3333, 16'h4444});

      // MONO token on an empty tag.
      send_token(1, PORT_L, 4'd2, 16'hBEEF, 0, f, p);
      if (BYPASS) check("mono_pkt", p, {4'd2, 16'hBEEF, 16'h0000});
      check("mono_fire", f, BYPASS);
      // MONO token on an occupied tag, then its real partner.
      send_token(0, PORT_L, 4'd4, 16'h1111, 0, f, p);
      send_token(1, PORT_L, 4'd4, 16'hCAFE, 0, f, p);
      send_token(0, PORT_R, 4'd4, 16'h2222, 0, f, p);

      // Randomized traffic on a few tags to provoke matches and collisions.
      for (int k = 0; k < 300; k++) begin
         send_token(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 3)), 16'($urandom),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0, f, p);
      end
      if (pending) complete_output();

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
